// File: rtl/core_defines.sv
// Shared RV32 core definitions: decoded op codes, hazard FSM state and control types,
// and the register-usage decode helpers used by the hazard logic.
package core_defines;

  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_BITS-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_BITS-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_BITS-1:0] OP_ADDI = 4'd3;
  localparam logic [OP_BITS-1:0] OP_LW   = 4'd4;
  localparam logic [OP_BITS-1:0] OP_LB   = 4'd5;
  localparam logic [OP_BITS-1:0] OP_SW   = 4'd6;
  localparam logic [OP_BITS-1:0] OP_SB   = 4'd7;
  localparam logic [OP_BITS-1:0] OP_BEQ  = 4'd8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZ    = 2'd1,
    ST_FREEZE = 2'd2,
    ST_FLUSH  = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic d_stall;
    logic ex_bubble;
    logic fd_flush;
  } hz_ctrl_t;

  function automatic logic uses_reg_a(input logic [OP_BITS-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_LB,
      OP_SW, OP_SB, OP_BEQ: return 1'b1;
      OP_NOP:               return 1'b0;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic uses_reg_b(input logic [OP_BITS-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SW, OP_SB, OP_BEQ: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // Writes to x0 are architecturally discarded, so they never count as a writer.
  function automatic logic writes_rd(input logic [OP_BITS-1:0] op, input logic rd_nonzero);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_LB: return rd_nonzero;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_sb.sv
// Three-slot (EX, MEM, WB) scoreboard of in-flight register writers with a
// decode-source match against the EX and MEM slots.
module hazard_sb #(
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             ins_valid,
  input  logic [REG_W-1:0] ins_rd,
  input  logic             ins_wr,
  input  logic             use_a,
  input  logic [REG_W-1:0] src_a,
  input  logic             use_b,
  input  logic [REG_W-1:0] src_b,
  output logic             src_match,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_wr
);

  logic             ex_valid;
  logic [REG_W-1:0] ex_rd;
  logic             ex_wr;
  logic             mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic             mem_wr;
  logic             hit_a;
  logic             hit_b;

  // Slots shift only when the pipeline advances; otherwise every slot holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_wr     <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_wr    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_wr     <= 1'b0;
    end else if (advance) begin
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_wr     <= mem_wr;
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_wr    <= ex_wr;
      ex_valid  <= ins_valid;
      ex_rd     <= ins_rd;
      ex_wr     <= ins_wr;
    end
  end

  // WB is left out on purpose: the register file forwards a same-cycle write to readers.
  always_comb begin
    hit_a = (src_a != '0) &&
            ((ex_valid && ex_wr && (ex_rd == src_a)) ||
             (mem_valid && mem_wr && (mem_rd == src_a)));
    hit_b = (src_b != '0) &&
            ((ex_valid && ex_wr && (ex_rd == src_b)) ||
             (mem_valid && mem_wr && (mem_rd == src_b)));
    src_match = (use_a && hit_a) || (use_b && hit_b);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall, bubble and flush generation around decode,
// write-back enable from the scoreboard, and a saturating stall-cycle counter.
module hazard_ctrl import core_defines::*; #(
  parameter int OP_W  = 4,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [OP_W-1:0]  d_op,
  input  logic [REG_W-1:0] d_regA,
  input  logic [REG_W-1:0] d_regB,
  input  logic [REG_W-1:0] d_regD,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             d_stall,
  output logic             ex_bubble,
  output logic             fd_flush,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_reg,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_t          state_q;
  hz_state_t          state_d;
  hz_ctrl_t           ctrl;
  logic [OP_BITS-1:0] op;
  logic               use_a;
  logic               use_b;
  logic               d_writes;
  logic               src_match;
  logic               hazard;
  logic               ins_valid;
  logic [REG_W-1:0]   ins_rd;
  logic               ins_wr;
  logic               sb_wb_valid;
  logic [REG_W-1:0]   sb_wb_rd;
  logic               sb_wb_wr;

  assign op       = OP_BITS'(d_op);
  assign use_a    = d_valid && uses_reg_a(op);
  assign use_b    = d_valid && uses_reg_b(op);
  assign d_writes = writes_rd(op, d_regD != '0);

  // In FLUSH the D/EX register carries a squashed slot, so its sources are meaningless.
  assign hazard = src_match && (state_q != ST_FLUSH);

  assign ins_valid = d_valid && !ctrl.ex_bubble;
  assign ins_rd    = ctrl.ex_bubble ? '0 : d_regD;
  assign ins_wr    = d_writes && !ctrl.ex_bubble;

  hazard_sb #(
    .REG_W(REG_W)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .advance   (!mem_busy),
    .ins_valid (ins_valid),
    .ins_rd    (ins_rd),
    .ins_wr    (ins_wr),
    .use_a     (use_a),
    .src_a     (d_regA),
    .use_b     (use_b),
    .src_b     (d_regB),
    .src_match (src_match),
    .wb_valid  (sb_wb_valid),
    .wb_rd     (sb_wb_rd),
    .wb_wr     (sb_wb_wr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A memory freeze outranks a taken branch, which outranks a data hazard.
  always_comb begin
    state_d = ST_RUN;
    if (mem_busy) begin
      state_d = ST_FREEZE;
    end else if (br_taken) begin
      state_d = ST_FLUSH;
    end else if (hazard) begin
      state_d = ST_HAZ;
    end
  end

  always_comb begin
    ctrl = '0;
    if (mem_busy) begin
      ctrl.pc_stall = 1'b1;
      ctrl.d_stall  = 1'b1;
    end else if (br_taken) begin
      ctrl.ex_bubble = 1'b1;
      ctrl.fd_flush  = 1'b1;
    end else if (hazard) begin
      ctrl.pc_stall  = 1'b1;
      ctrl.d_stall   = 1'b1;
      ctrl.ex_bubble = 1'b1;
    end
  end

  assign pc_stall  = ctrl.pc_stall;
  assign d_stall   = ctrl.d_stall;
  assign ex_bubble = ctrl.ex_bubble;
  assign fd_flush  = ctrl.fd_flush;

  // A writer parked in WB during a freeze retires on the first free cycle, so it writes once.
  assign wb_en  = sb_wb_valid && sb_wb_wr && !mem_busy;
  assign wb_reg = sb_wb_rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (ctrl.pc_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic, all checked
// against a register-readiness / retire-countdown reference model.
module tb_hazard_ctrl;

  localparam int OP_W    = 4;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             d_valid = 1'b0;
  logic [OP_W-1:0]  d_op = '0;
  logic [REG_W-1:0] d_regA = '0;
  logic [REG_W-1:0] d_regB = '0;
  logic [REG_W-1:0] d_regD = '0;
  logic             br_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_stall;
  logic             d_stall;
  logic             ex_bubble;
  logic             fd_flush;
  logic             wb_en;
  logic [REG_W-1:0] wb_reg;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clock = ~clock;

  hazard_ctrl #(
    .OP_W (OP_W),
    .REG_W(REG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_op     (d_op),
    .d_regA   (d_regA),
    .d_regB   (d_regB),
    .d_regD   (d_regD),
    .br_taken (br_taken),
    .mem_busy (mem_busy),
    .pc_stall (pc_stall),
    .d_stall  (d_stall),
    .ex_bubble(ex_bubble),
    .fd_flush (fd_flush),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    int rd;
    int left;
  } retire_t;

  int      assert_count = 0;
  int      fail_count = 0;
  int      ready_in[32];
  retire_t retire_q[$];
  bit      m_flush;
  int      m_cnt;
  bit      e_pc;
  bit      e_bub;
  bit      e_fl;
  bit      e_wb;
  int      e_wbreg;
  int      c0;

  // ready_in[r] counts advancing cycles until a pending write to r is visible to decode.
  function automatic void model_reset();
    foreach (ready_in[i]) ready_in[i] = 0;
    retire_q.delete();
    m_flush = 1'b0;
    m_cnt   = 0;
  endfunction

  function automatic bit reads_a(input int op);
    return (op >= 1) && (op <= 8);
  endfunction

  function automatic bit reads_b(input int op);
    return (op == 1) || (op == 2) || ((op >= 6) && (op <= 8));
  endfunction

  function automatic bit writes(input int op, input int rd);
    return (op >= 1) && (op <= 5) && (rd != 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input int op, input int a, input int b,
                               input int d, input bit br, input bit busy);
    bit      hz;
    retire_t keep[$];
    retire_t t;
    @(negedge clock);
    reset    = rst;
    d_valid  = v;
    d_op     = 4'(op);
    d_regA   = 5'(a);
    d_regB   = 5'(b);
    d_regD   = 5'(d);
    br_taken = br;
    mem_busy = busy;
    if (!rst) model_reset();
    hz = v && ((reads_a(op) && (a != 0) && (ready_in[a] > 0)) ||
               (reads_b(op) && (b != 0) && (ready_in[b] > 0)));
    e_pc  = 1'b0;
    e_bub = 1'b0;
    e_fl  = 1'b0;
    if (busy) begin
      e_pc = 1'b1;
    end else if (br) begin
      e_bub = 1'b1;
      e_fl  = 1'b1;
    end else if (hz && !m_flush) begin
      e_pc  = 1'b1;
      e_bub = 1'b1;
    end
    e_wb    = 1'b0;
    e_wbreg = 0;
    if (!busy) begin
      foreach (retire_q[i]) begin
        if (retire_q[i].left == 0) begin
          e_wb    = 1'b1;
          e_wbreg = retire_q[i].rd;
        end
      end
    end
    #1;
    checkOutput("pc_stall", pc_stall, e_pc);
    checkOutput("d_stall", d_stall, e_pc);
    checkOutput("ex_bubble", ex_bubble, e_bub);
    checkOutput("fd_flush", fd_flush, e_fl);
    checkOutput("wb_en", wb_en, e_wb);
    if (e_wb) checkOutput("wb_reg", wb_reg, e_wbreg);
    checkOutput("stall_cnt", stall_cnt, m_cnt);
    @(posedge clock);
    if (rst) begin
      if (e_pc && (m_cnt < CNT_MAX)) m_cnt++;
      if (!busy) begin
        foreach (ready_in[r]) if (ready_in[r] > 0) ready_in[r]--;
        foreach (retire_q[i]) begin
          if (retire_q[i].left > 0) begin
            t.rd   = retire_q[i].rd;
            t.left = retire_q[i].left - 1;
            keep.push_back(t);
          end
        end
        retire_q = keep;
        if (!e_bub && v && writes(op, d)) begin
          ready_in[d] = 2;
          t.rd   = d;
          t.left = 2;
          retire_q.push_back(t);
        end
        m_flush = br;
      end else begin
        m_flush = 1'b0;
      end
    end
  endtask

  // Holds one instruction in D/EX until the controller lets it issue.
  task automatic issue(input int op, input int a, input int b, input int d);
    int n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, op, a, b, d, 1'b0, 1'b0);
      n++;
    end while (e_pc && (n < 20));
    checkOutput("issue_bound", n < 20, 1);
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    drain(1);

    $display("[TB] back-to-back RAW: ADD x5 then SUB x6,x5,x1");
    issue(1, 1, 2, 5);
    issue(2, 5, 1, 6);
    #1 checkOutput("raw_stall_cnt", stall_cnt, 2);
    drain(3);

    $display("[TB] load with one-instruction gap");
    c0 = m_cnt;
    issue(4, 1, 0, 7);
    issue(1, 1, 2, 9);
    issue(3, 7, 0, 8);
    #1 checkOutput("gap1_stalls", stall_cnt, c0 + 1);
    drain(3);
    c0 = m_cnt;
    issue(4, 1, 0, 0);
    issue(1, 1, 2, 9);
    issue(3, 0, 0, 8);
    #1 checkOutput("gap1_x0_stalls", stall_cnt, c0);
    drain(3);

    $display("[TB] taken branch squashes two slots");
    issue(8, 1, 2, 0);
    applyStimulus(1'b1, 1'b1, 1, 3, 4, 10, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    issue(1, 10, 11, 12);
    drain(3);

    $display("[TB] memory freeze during a hazard stall");
    c0 = m_cnt;
    issue(1, 1, 2, 5);
    applyStimulus(1'b1, 1'b1, 2, 5, 1, 6, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 2, 5, 1, 6, 1'b0, 1'b1);
    issue(2, 5, 1, 6);
    #1 checkOutput("freeze_stall_cnt", stall_cnt, c0 + 5);
    drain(3);

    $display("[TB] branch and freeze together");
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    drain(3);

    $display("[TB] reset mid-stall with three writers in flight");
    issue(1, 0, 0, 1);
    issue(1, 0, 0, 2);
    issue(1, 0, 0, 3);
    @(negedge clock);
    d_valid = 1'b1; d_op = 4'd2; d_regA = 5'd3; d_regB = 5'd0; d_regD = 5'd4;
    br_taken = 1'b0; mem_busy = 1'b0;
    #1;
    checkOutput("pre_reset_stall", pc_stall, 1);
    checkOutput("pre_reset_wb_en", wb_en, 1);
    checkOutput("pre_reset_wb_reg", wb_reg, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checkOutput("reset_pc_stall", pc_stall, 0);
    checkOutput("reset_ex_bubble", ex_bubble, 0);
    checkOutput("reset_wb_en", wb_en, 0);
    checkOutput("reset_stall_cnt", stall_cnt, 0);
    repeat (2) applyStimulus(1'b0, 1'b1, 2, 3, 0, 4, 1'b0, 1'b0);
    drain(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 10), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0);
    end

    $display("[TB] stall counter saturation");
    repeat (CNT_MAX + 8) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    #1 checkOutput("stall_cnt_saturated", stall_cnt, CNT_MAX);
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core (F, D, EX, MEM, WB). Tracks in-flight register writers in a 3-slot scoreboard. Generates same-cycle stall, bubble and flush controls around the decode stage, and drives the register-file write enable and write address at WB. It sits beside the decode stage and consumes its registered D/EX outputs (op, regA, regB, regD), plus branch resolution from EX and a busy flag from data memory.

## Interface
Parameters:
- OP_W, 4, width of the decoded op code
- REG_W, 5, register index width
- CNT_W, 32, width of the stall performance counter

Ports:
- clock  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- d_valid  in  1  D/EX register holds a real instruction
- d_op  in  OP_W  decoded op: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 LW, 5 LB, 6 SW, 7 SB, 8 BEQ
- d_regA, d_regB, d_regD  in  REG_W  source and destination indices from decode
- br_taken  in  1  branch in EX resolved taken; held by EX until EX advances
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze
- pc_stall  out  1  hold PC and the F/D register
- d_stall  out  1  hold the D/EX register
- ex_bubble  out  1  load a NOP into EX instead of the D/EX contents
- fd_flush  out  1  clear the F/D register to NOP
- wb_en  out  1  register-file write enable
- wb_reg  out  REG_W  register-file write address
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating

## Operation
- **Scoreboard slots:** EX, MEM and WB. Each slot holds {valid, rd, wr}.
- **Write flag:** wr=1 iff op ∈ {1,2,3,4,5} and rd≠0.
- **Source usage:**
  - ops 1, 2, 6, 7, 8 read regA and regB.
  - ops 3, 4, 5 read regA only.
  - op 0 reads nothing.
  - Register x0 never matches.
- **Hazard:** raised when d_valid and a used source equals rd of a valid EX or MEM slot with wr=1.
  - A WB-slot match does not stall, because the register file is write-through.
- **States:** RUN, HAZ, FREEZE, FLUSH.
- **Priority:** mem_busy > br_taken > hazard.
- **Behaviour per condition** (the listed state is the next state):
  - mem_busy=1: scoreboard holds, pc_stall=d_stall=1, ex_bubble=0, fd_flush=0, wb_en=0. Next state FREEZE. br_taken is ignored until mem_busy=0.
  - br_taken=1: ex_bubble=1, fd_flush=1, no stall. Next state FLUSH.
  - hazard: pc_stall=d_stall=1, ex_bubble=1. Next state HAZ.
  - otherwise: all controls 0. Next state RUN.
- **FLUSH:** lasts exactly one cycle. Hazard checking is suppressed because D/EX holds the decode of the flushed NOP. Next state follows the priority rules above.
- **Advance (mem_busy=0):**
  - WB ← MEM, MEM ← EX.
  - EX ← {d_valid, d_regD, wr(d_op)} when ex_bubble=0, otherwise an invalid slot.
- **Write-back:** wb_en = WB.valid & WB.wr & ~mem_busy; wb_reg = WB.rd. wb_en is asserted exactly once per retiring writer.
- **stall_cnt:** +1 on each cycle with pc_stall=1; saturates at all-ones.

## Timing
- pc_stall, d_stall, ex_bubble, fd_flush, wb_en and wb_reg are combinational from the current state, scoreboard and inputs. They take effect at the same clock edge.
- Scoreboard, state and stall_cnt are registered.
- **Reset values:** all slots invalid, state RUN, stall_cnt=0. All outputs therefore read 0 during and after reset.
- **Reset mid-operation:** in-flight writers are discarded with no wb_en.
- **Stall latency:**
  - A dependent instruction directly behind a writer stalls 2 cycles (writer in EX, then in MEM).
  - Gap of one instruction: 1 stall cycle.
  - Gap of two or more: none.
- **Branch cost:** 2 squashed instructions; the target enters F the cycle after br_taken.
- **mem_busy and br_taken together:** the freeze wins. The flush happens on the first cycle with mem_busy=0.
- **mem_busy during HAZ:** FREEZE takes over. Hazard is re-evaluated on release.

## Structure
- Op-code constants (NOP through BEQ) and the state enum go in the shared core_defines package.
- The uses-regA / uses-regB / writes-rd decode helpers also go in that package.
- One sub-module: hazard_sb, the 3-slot scoreboard with advance/insert/hold ports and a source-match output. The FSM, output logic and counter remain in hazard_ctrl.

## Test plan
- ADD x5 followed immediately by SUB x6,x5,x1 → pc_stall=1 for 2 cycles; stall_cnt=2; wb_en with wb_reg=5 precedes SUB entering EX.
- LW x7 then an unrelated instruction, then ADDI x8,x7 → exactly 1 stall cycle. Same sequence with x0 as the destination → 0 stalls.
- BEQ taken (br_taken=1 for 1 cycle) → fd_flush=ex_bubble=1 that cycle; FLUSH for 1 cycle; no wb_en from the two squashed instructions.
- mem_busy=1 for 3 cycles during a hazard stall → FREEZE, wb_en=0, scoreboard unchanged. After release: remaining stall cycles, then issue.
- br_taken and mem_busy asserted together for 2 cycles → no flush while frozen; flush on the first free cycle.
- Reset pulled low mid-stall with 3 valid slots → outputs 0 immediately; no wb_en after release; stall_cnt=0.
